// File: rtl/nanoz80_pkg.sv
// Shared definitions for the nano-Z80 peripheral set: interrupt controller
// register map, timer source index and TCTL bit positions.
package nanoz80_pkg;

    typedef enum logic [2:0] {
        IRQ_PEND   = 3'd0,
        IRQ_MASK   = 3'd1,
        IRQ_VBASE  = 3'd2,
        IRQ_RLD_LO = 3'd3,
        IRQ_RLD_HI = 3'd4,
        IRQ_TCTL   = 3'd5
    } irq_reg_e;

    localparam int TIMER_SRC     = 7;
    localparam int TCTL_RUN_BIT  = 0;
    localparam int TCTL_AUTO_BIT = 1;

    // Lowest set bit wins; an empty set yields index 0.
    function automatic logic [2:0] irq_prio_idx(input logic [7:0] act);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (act[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_timer.sv
// 16-bit down counter with reload; raises tick for one clock at count 0.
module irq_timer (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        load_i,
    input  logic        run_i,
    input  logic        autoreload_i,
    input  logic [15:0] reload_i,
    output logic        tick_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: load wins, otherwise count down while running; wrap or park at 0.
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (load_i) begin
            cnt_d = reload_i;
        end else if (run_i) begin
            if (cnt_q == 16'd0) begin
                tick_o = 1'b1;
                cnt_d  = autoreload_i ? reload_i : 16'd0;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// nano-Z80 interrupt controller: edge-triggered pending bits, mask, IM2
// vector generation for the M1+IORQ acknowledge, and an interval timer on
// source 7.
module irq_ctrl
    import nanoz80_pkg::*;
#(
    parameter int NUM_EXT = 7
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               wr_n,
    input  logic               m1_n,
    input  logic               ioreq_n,
    input  logic               irq_cs,
    input  logic [2:0]         reg_addr_i,
    input  logic [7:0]         data_i,
    input  logic [NUM_EXT-1:0] irq_i,
    output logic [7:0]         data_o,
    output logic               ack_o,
    output logic               int_n_o
);

    logic               inta;
    logic               wr_stb;
    logic               we;
    logic               tick;
    logic               timer_load;
    logic               ack_clr;
    logic [7:0]         act;
    logic [7:0]         set_bits;
    logic [7:0]         clr_bits;

    logic               wr_q,     wr_d;
    logic               inta_q,   inta_d;
    logic [NUM_EXT-1:0] irq_q,    irq_d;
    logic [7:0]         pend_q,   pend_d;
    logic [7:0]         mask_q,   mask_d;
    logic [2:0]         vbase_q,  vbase_d;
    logic [7:0]         rld_lo_q, rld_lo_d;
    logic [7:0]         rld_hi_q, rld_hi_d;
    logic               run_q,    run_d;
    logic               auto_q,   auto_d;
    logic               int_n_q,  int_n_d;
    logic [7:0]         vec_q,    vec_d;
    logic [7:0]         rd_q,     rd_d;

    assign inta    = ~m1_n & ~ioreq_n;
    assign ack_o   = inta;
    assign wr_stb  = irq_cs & ~wr_n;
    // Only the first clock of a write strobe counts, and never during acknowledge.
    assign we      = wr_stb & ~wr_q & ~inta;
    assign act     = pend_q & mask_q;
    // Clear the acknowledged source once IORQ/M1 drop, unless nothing was pending.
    assign ack_clr = inta_q & ~inta & ~vec_q[4];
    assign timer_load = we && (reg_addr_i == IRQ_TCTL) && data_i[TCTL_RUN_BIT];

    assign data_o  = inta ? vec_q : rd_q;
    assign int_n_o = int_n_q;

    irq_timer u_timer (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .load_i       (timer_load),
        .run_i        (run_q),
        .autoreload_i (auto_q),
        .reload_i     ({rld_hi_q, rld_lo_q}),
        .tick_o       (tick)
    );

    // Register writes, pending set/clear (set dominates) and one-shot run clear.
    always_comb begin
        set_bits            = 8'h00;
        set_bits[6:0]       = 7'(irq_i & ~irq_q);
        set_bits[TIMER_SRC] = tick;

        clr_bits = 8'h00;
        if (ack_clr) clr_bits[vec_q[3:1]] = 1'b1;

        mask_d   = mask_q;
        vbase_d  = vbase_q;
        rld_lo_d = rld_lo_q;
        rld_hi_d = rld_hi_q;
        run_d    = run_q;
        auto_d   = auto_q;

        if (tick && !auto_q) run_d = 1'b0;

        if (we) begin
            case (reg_addr_i)
                IRQ_PEND:   clr_bits = clr_bits | data_i;
                IRQ_MASK:   mask_d   = data_i;
                IRQ_VBASE:  vbase_d  = data_i[7:5];
                IRQ_RLD_LO: rld_lo_d = data_i;
                IRQ_RLD_HI: rld_hi_d = data_i;
                IRQ_TCTL: begin
                    run_d  = data_i[TCTL_RUN_BIT];
                    auto_d = data_i[TCTL_AUTO_BIT];
                end
                default: ;
            endcase
        end

        pend_d = (pend_q & ~clr_bits) | set_bits;
    end

    // Interrupt line, vector (frozen during acknowledge) and edge/strobe history.
    always_comb begin
        int_n_d = ~|act;
        vec_d   = inta ? vec_q : {vbase_q, ~|act, irq_prio_idx(act), 1'b0};
        wr_d    = wr_stb;
        inta_d  = inta;
        irq_d   = irq_i;
    end

    // Registered read-back of the register addressed this clock.
    always_comb begin
        rd_d = 8'h00;
        case (reg_addr_i)
            IRQ_PEND:   rd_d = pend_q;
            IRQ_MASK:   rd_d = mask_q;
            IRQ_VBASE:  rd_d = {vbase_q, 5'b00000};
            IRQ_RLD_LO: rd_d = rld_lo_q;
            IRQ_RLD_HI: rd_d = rld_hi_q;
            IRQ_TCTL:   rd_d = {6'b000000, auto_q, run_q};
            default:    rd_d = 8'h00;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q     <= 1'b0;
            inta_q   <= 1'b0;
            irq_q    <= '0;
            pend_q   <= 8'h00;
            mask_q   <= 8'h00;
            vbase_q  <= 3'd0;
            rld_lo_q <= 8'h00;
            rld_hi_q <= 8'h00;
            run_q    <= 1'b0;
            auto_q   <= 1'b0;
            int_n_q  <= 1'b1;
            vec_q    <= 8'h00;
            rd_q     <= 8'h00;
        end else begin
            wr_q     <= wr_d;
            inta_q   <= inta_d;
            irq_q    <= irq_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            vbase_q  <= vbase_d;
            rld_lo_q <= rld_lo_d;
            rld_hi_q <= rld_hi_d;
            run_q    <= run_d;
            auto_q   <= auto_d;
            int_n_q  <= int_n_d;
            vec_q    <= vec_d;
            rd_q     <= rd_d;
        end
    end

endmodule
